// File: rtl/lfsr_pkg.sv
// Shared XNOR LFSR definitions: tap table, step function, lockup constant, checker FSM states.
package lfsr_pkg;

  localparam logic [31:0] LFSR_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // 0-based tap masks for maximal-length XNOR LFSRs of 3..32 bits
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] m;
    case (width)
      3:  m = 32'h0000_0006;
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lfsr_next(input int unsigned width, input logic [31:0] word);
    logic [31:0] wmask;
    logic        fb;
    wmask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    fb    = ~^(word & lfsr_taps(width));
    return ({word[30:0], fb}) & wmask;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step advance of an XNOR LFSR word, taps taken from lfsr_pkg.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] word_i,
  output logic [NUM_BITS-1:0] next_o
);

  localparam logic [31:0]         TAPS_ALL = lfsr_taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK = TAPS_ALL[NUM_BITS-1:0];

  assign next_o = {word_i[NUM_BITS-2:0], ~^(word_i & TAP_MASK)};

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising XNOR PRBS checker with lock/loss detection and error counting.
// Build option LFSR_CHK_BITERR_EN: count bit errors instead of word errors.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 4,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Data_DV,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear,
  output logic                o_Locked,
  output logic                o_Err_Pulse,
  output logic [ERR_W-1:0]    o_Err_Count,
  output logic [31:0]         o_Word_Count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int SW = ERR_W + 7;
  localparam logic [NUM_BITS-1:0] ALL_ONES   = LFSR_ALL_ONES[NUM_BITS-1:0];
  localparam logic [MW-1:0]       MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0]       BAD_LAST   = LW'(LOSS_CNT - 1);
  localparam logic [ERR_W-1:0]    ERR_MAX    = {ERR_W{1'b1}};

  chk_state_e          state_q, state_d;
  logic [NUM_BITS-1:0] expect_q, expect_d;
  logic [MW-1:0]       match_q, match_d;
  logic [LW-1:0]       bad_q, bad_d;
  logic                locked_q, locked_d;
  logic                pulse_q, pulse_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [31:0]         words_q, words_d;

  logic [NUM_BITS-1:0] seed_next, fly_next;
  logic                data_ones, data_match;
  logic [6:0]          err_inc;
  logic [ERR_W-1:0]    err_room, err_sat;

  lfsr_step #(.NUM_BITS(NUM_BITS)) u_seed_step (.word_i(i_Data),   .next_o(seed_next));
  lfsr_step #(.NUM_BITS(NUM_BITS)) u_fly_step  (.word_i(expect_q), .next_o(fly_next));

  assign data_ones  = (i_Data == ALL_ONES);
  assign data_match = (i_Data == expect_q);

`ifdef LFSR_CHK_BITERR_EN
  function automatic logic [6:0] popcount(input logic [NUM_BITS-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < NUM_BITS; i++) c = c + 7'(v[i]);
    return c;
  endfunction

  assign err_inc = popcount(i_Data ^ expect_q);
`else
  assign err_inc = 7'd1;
`endif

  // Saturate when the increment would not fit in the remaining headroom
  assign err_room = ERR_MAX - err_q;
  assign err_sat  = (SW'(err_room) < SW'(err_inc)) ? ERR_MAX : (err_q + ERR_W'(err_inc));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q  <= ST_HUNT;
      expect_q <= '0;
      match_q  <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
      match_q  <= match_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
      words_q  <= words_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    match_d  = match_q;
    bad_d    = bad_q;
    pulse_d  = 1'b0;
    err_d    = err_q;
    words_d  = words_q;

    if (i_Data_DV) begin
      case (state_q)
        ST_HUNT: begin
          if (!data_ones) begin
            expect_d = seed_next;
            match_d  = '0;
            state_d  = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (data_match) begin
            expect_d = seed_next;
            if (match_q == MATCH_LAST) begin
              match_d = '0;
              bad_d   = '0;
              state_d = ST_LOCKED;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else if (data_ones) begin
            state_d = ST_HUNT;
          end else begin
            expect_d = seed_next;
            match_d  = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: prediction runs on its own, received data is only compared
          expect_d = fly_next;
          words_d  = words_q + 32'd1;
          if (data_match) begin
            bad_d = '0;
          end else begin
            pulse_d = 1'b1;
            err_d   = err_sat;
            if (bad_q == BAD_LAST) begin
              bad_d   = '0;
              state_d = ST_HUNT;
            end else begin
              bad_d = bad_q + LW'(1);
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (i_Clear) begin
      err_d   = '0;
      words_d = '0;
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  assign o_Locked     = locked_q;
  assign o_Err_Pulse  = pulse_q;
  assign o_Err_Count  = err_q;
  assign o_Word_Count = words_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker with a reference model feeding an expectation queue.
module tb_lfsr_prbs_checker;

`ifdef LFSR_CHK_BITERR_EN
  localparam int INC4 = 4;
`else
  localparam int INC4 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, dv, clr;
  logic [3:0]  data;
  logic        locked, pulse, s_locked, s_pulse;
  logic [15:0] err;
  logic [1:0]  s_err;
  logic [31:0] words, s_words;

  always #5 clk = ~clk;

  lfsr_prbs_checker #(.NUM_BITS(4), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) u_dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Data_DV(dv), .i_Data(data), .i_Clear(clr),
    .o_Locked(locked), .o_Err_Pulse(pulse), .o_Err_Count(err), .o_Word_Count(words));

  lfsr_prbs_checker #(.NUM_BITS(4), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) u_sat (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Data_DV(dv), .i_Data(data), .i_Clear(clr),
    .o_Locked(s_locked), .o_Err_Pulse(s_pulse), .o_Err_Count(s_err), .o_Word_Count(s_words));

  typedef struct {
    logic        locked;
    logic        pulse;
    logic [15:0] err;
    logic [1:0]  serr;
    logic [31:0] words;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // reference model: 0 hunt, 1 verify, 2 locked
  int          m_state = 0;
  logic [3:0]  m_exp   = 4'h0;
  int          m_match = 0;
  int          m_bad   = 0;
  int          m_err   = 0;
  int          m_serr  = 0;
  logic [31:0] m_words = 32'd0;
  logic        m_pulse = 1'b0;
  logic [3:0]  cur     = 4'h0;

  function automatic logic [3:0] nx(input logic [3:0] w);
    return {w[2:0], ~(w[3] ^ w[2])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [3:0] d, input logic c);
    int inc;
    m_pulse = 1'b0;
    if (!r) begin
      m_state = 0; m_exp = 4'h0; m_match = 0; m_bad = 0;
      m_err = 0; m_serr = 0; m_words = 32'd0;
      return;
    end
    if (v) begin
      if (m_state == 0) begin
        if (d != 4'hF) begin
          m_exp = nx(d); m_match = 0; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (d == m_exp) begin
          m_exp = nx(d);
          m_match++;
          if (m_match == 4) begin
            m_state = 2; m_bad = 0;
          end
        end else if (d == 4'hF) begin
          m_state = 0;
        end else begin
          m_exp = nx(d); m_match = 0;
        end
      end else begin
        m_words = m_words + 32'd1;
        if (d != m_exp) begin
`ifdef LFSR_CHK_BITERR_EN
          inc = $countones(d ^ m_exp);
`else
          inc = 1;
`endif
          m_pulse = 1'b1;
          m_err   = (m_err + inc > 65535) ? 65535 : m_err + inc;
          m_serr  = (m_serr + inc > 3) ? 3 : m_serr + inc;
          m_bad++;
          if (m_bad == 3) begin
            m_state = 0; m_bad = 0;
          end
        end else begin
          m_bad = 0;
        end
        m_exp = nx(m_exp);
      end
    end
    if (c) begin
      m_err = 0; m_serr = 0; m_words = 32'd0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] d, input logic c);
    exp_t e;
    rst_n = r; dv = v; data = d; clr = c;
    model_step(r, v, d, c);
    e.locked = (m_state == 2);
    e.pulse  = m_pulse;
    e.err    = 16'(m_err);
    e.serr   = 2'(m_serr);
    e.words  = m_words;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("locked", 32'(locked), 32'(e.locked));
    chk("pulse",  32'(pulse),  32'(e.pulse));
    chk("err",    32'(err),    32'(e.err));
    chk("words",  words,       e.words);
    chk("sat_err", 32'(s_err), 32'(e.serr));
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, cur, 1'b0);
      cur = nx(cur);
    end
  endtask

  task automatic corrupt(input logic [3:0] flip, input logic c);
    step(1'b1, 1'b1, cur ^ flip, c);
    cur = nx(cur);
  endtask

  task automatic gap();
    step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; dv = 1'b0; data = 4'h0; clr = 1'b0;

    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // clean stream from 0000: lock appears after the fifth word
    cur = 4'h0;
    clean(4);
    chk("pre_lock", 32'(locked), 32'd0);
    clean(1);
    chk("lock_5th", 32'(locked), 32'd1);
    clean(3);
    chk("clean_err", 32'(err), 32'd0);
    chk("clean_words", words, 32'd3);

    // single-bit then four-bit corruption while locked
    corrupt(4'b0100, 1'b0);
    chk("err1_pulse", 32'(pulse), 32'd1);
    chk("err1_count", 32'(err), 32'd1);
    chk("err1_locked", 32'(locked), 32'd1);
    clean(1);
    chk("err1_pulse_end", 32'(pulse), 32'd0);
    corrupt(4'b1111, 1'b0);
    chk("err4_count", 32'(err), 32'(1 + INC4));
    clean(1);

    // three consecutive bad words drop lock
    corrupt(4'b0001, 1'b0);
    corrupt(4'b0001, 1'b0);
    chk("loss_hold", 32'(locked), 32'd1);
    corrupt(4'b0001, 1'b0);
    chk("loss_drop", 32'(locked), 32'd0);
    chk("loss_err", 32'(err), 32'(4 + INC4));
    chk("loss_sat", 32'(s_err), 32'd3);
    clean(4);
    chk("relock_pre", 32'(locked), 32'd0);
    clean(1);
    chk("relock", 32'(locked), 32'd1);

    // clear together with an error word, then saturation of the narrow counter
    corrupt(4'b0010, 1'b1);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_pulse", 32'(pulse), 32'd1);
    chk("clr_words", words, 32'd0);
    chk("clr_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 5; i++) begin
      corrupt(4'b1000, 1'b0);
      clean(1);
    end
    chk("five_err", 32'(err), 32'd5);
    chk("sat_three", 32'(s_err), 32'd3);
    chk("five_locked", 32'(locked), 32'd1);

    // constant all-ones never leaves hunt
    step(1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'hF, 1'b0);
    chk("ones_locked", 32'(locked), 32'd0);
    chk("ones_err", 32'(err), 32'd0);

    // gapped stream, reset mid-lock, gapped relock
    cur = 4'h3;
    for (int i = 0; i < 5; i++) begin
      clean(1);
      gap();
    end
    chk("gap_lock", 32'(locked), 32'd1);
    clean(2);
    gap();
    gap();
    clean(2);
    chk("gap_noerr", 32'(err), 32'd0);
    step(1'b0, 1'b1, cur, 1'b0);
    cur = nx(cur);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_words", words, 32'd0);
    for (int i = 0; i < 4; i++) begin
      gap();
      clean(1);
    end
    chk("gap_relock_pre", 32'(locked), 32'd0);
    gap();
    chk("gap_hold", 32'(locked), 32'd0);
    clean(1);
    chk("gap_relock", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
